scpu_ifetch: RTL and testbench

- Instruction fetch stage directly upstream of the single-cycle controller.
- Owns the PC and fetches one instruction word per retire through a request/ready handshake with instruction memory.
- Holds the instruction stable and presents the opcode, funct3 and funct7[5] fields to the controller.
- Computes the next PC from the controller's Jump/Branch/BranchN outputs, the ALU zero flag, the immediate and the ALU result.

---
 rtl/scpu_ifetch.sv | 130 +++++++++++++
 tb/tb_scpu_ifetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scpu_ifetch.sv
// scpu_ifetch: instruction fetch stage for the single-cycle controller.
//
// Owns the program counter, fetches one instruction word per retire through
// a request/ready handshake, holds it stable for the execute stage and
// resolves the next PC from the controller's jump/branch decisions.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   imem_req/imem_addr   fetch request and address (address == pc)
//   imem_rdata/ready     instruction word, accepted in the same cycle
//   inst/inst_valid      held instruction and its valid flag
//   OPcode/Fun3/Fun7     decode fields sliced from inst
//   pc/pc_plus4          current pc and its sequential successor
//   retire               execute stage consumed inst this cycle
//   Jump/Branch/BranchN  control-flow decisions from the controller
//   zero/imm/alu_res     ALU flag, immediate and jalr target
//   fetch_misalign       sticky flag: a computed next pc was not word-aligned
module scpu_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [6:0]  OPcode,
  output logic [2:0]  Fun3,
  output logic        Fun7,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic [1:0]  Jump,
  input  logic        Branch,
  input  logic        BranchN,
  input  logic        zero,
  input  logic [31:0] imm,
  input  logic [31:0] alu_res,
  output logic        fetch_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic        inst_valid_reg;
  logic        misalign_reg;

  logic [31:0] pc_next;
  logic [31:0] pc_imm;
  logic        br_taken;

  // jalr always clears bit 0 of its target; bit 0 is otherwise unused here.
  logic unused_alu_bit0;
  assign unused_alu_bit0 = alu_res[0];

  // Next-pc resolution. jalr outranks jal, so Jump==2'b11 behaves as jalr;
  // with both branch kinds asserted, either satisfied condition takes it.
  always_comb begin
    pc_imm   = pc_reg + imm;
    br_taken = (Branch & zero) | (BranchN & ~zero);
    pc_next  = pc_reg + 32'd4;
    if (Jump[1]) begin
      pc_next = {alu_res[31:1], 1'b0};
    end else if (Jump[0] || br_taken) begin
      pc_next = pc_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      inst_reg       <= NOP;
      inst_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem_ready) begin
            inst_reg       <= imem_rdata;
            inst_valid_reg <= 1'b1;
            state_reg      <= HOLD;
          end
        end
        HOLD: begin
          if (retire) begin
            // The misaligned target is still loaded so it can be inspected.
            pc_reg         <= pc_next;
            inst_valid_reg <= 1'b0;
            if (pc_next[1:0] != 2'b00) begin
              state_reg    <= HALT;
              misalign_reg <= 1'b1;
            end else begin
              state_reg    <= FETCH;
            end
          end
        end
        HALT: begin
          inst_valid_reg <= 1'b0;
        end
        default: begin
          state_reg      <= HALT;
          inst_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req       = (state_reg == FETCH);
  assign imem_addr      = pc_reg;
  assign pc             = pc_reg;
  assign pc_plus4       = pc_reg + 32'd4;
  assign inst           = inst_reg;
  assign inst_valid     = inst_valid_reg;
  assign OPcode         = inst_reg[6:0];
  assign Fun3           = inst_reg[14:12];
  assign Fun7           = inst_reg[30];
  assign fetch_misalign = misalign_reg;

endmodule

// File: tb/tb_scpu_ifetch.sv
// tb_scpu_ifetch: randomized self-checking bench for scpu_ifetch.
// A behavioural model tracks pc, held instruction and halt status from the
// fetch/retire rules; outputs are compared every cycle on the falling edge.
module tb_scpu_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [6:0]  OPcode;
  logic [2:0]  Fun3;
  logic        Fun7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire = 1'b0;
  logic [1:0]  Jump = 2'b00;
  logic        Branch = 1'b0;
  logic        BranchN = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] imm = 32'd0;
  logic [31:0] alu_res = 32'd0;
  logic        fetch_misalign;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_valid;
  logic        m_halt;
  logic        m_mis;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[9:2]];

  scpu_ifetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .inst(inst), .inst_valid(inst_valid),
    .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7),
    .pc(pc), .pc_plus4(pc_plus4),
    .retire(retire), .Jump(Jump), .Branch(Branch), .BranchN(BranchN),
    .zero(zero), .imm(imm), .alu_res(alu_res),
    .fetch_misalign(fetch_misalign)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_inst  = NOP;
    m_valid = 1'b0;
    m_halt  = 1'b0;
    m_mis   = 1'b0;
  endtask

  function automatic logic [31:0] target_pc();
    if (Jump[1]) return alu_res & 32'hFFFF_FFFE;
    if (Jump[0] || (Branch && zero) || (BranchN && !zero)) return m_pc + imm;
    return m_pc + 32'd4;
  endfunction

  // Called on a falling edge: compare, advance the model over the next
  // rising edge using the inputs currently applied, return on the next fall.
  task automatic run_cycle();
    logic [31:0] t;
    check_eq("imem_req",   imem_req,   !m_valid && !m_halt);
    check_eq("imem_addr",  imem_addr,  m_pc);
    check_eq("pc",         pc,         m_pc);
    check_eq("pc_plus4",   pc_plus4,   m_pc + 32'd4);
    check_eq("inst_valid", inst_valid, m_valid);
    check_eq("inst",       inst,       m_inst);
    check_eq("OPcode",     OPcode,     m_inst & 32'h7F);
    check_eq("Fun3",       Fun3,       (m_inst >> 12) & 32'h7);
    check_eq("Fun7",       Fun7,       (m_inst >> 30) & 32'h1);
    check_eq("misalign",   fetch_misalign, m_mis);
    @(posedge clk);
    if (!m_halt) begin
      if (!m_valid) begin
        if (imem_ready) begin
          m_inst  = mem[m_pc[9:2]];
          m_valid = 1'b1;
        end
      end else if (retire) begin
        t       = target_pc();
        m_pc    = t;
        m_valid = 1'b0;
        if (t[1:0] != 2'b00) begin
          m_halt = 1'b1;
          m_mis  = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  // Asserted shortly after a falling edge so the effect is visibly immediate.
  task automatic apply_reset(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_pc",       pc,             RESET_PC);
    check_eq("rst_valid",    inst_valid,     32'd0);
    check_eq("rst_misalign", fetch_misalign, 32'd0);
    check_eq("rst_inst",     inst,           NOP);
    model_reset();
    for (int i = 0; i < cycles; i++) @(negedge clk);
    rst_n = 1'b1;
    $display("reset applied for %0d cycles", cycles);
  endtask

  task automatic set_np(input logic [1:0] j, input logic b, input logic bn,
                        input logic z, input logic [31:0] iv, input logic [31:0] av);
    Jump = j; Branch = b; BranchN = bn; zero = z; imm = iv; alu_res = av;
  endtask

  // Wait for a held instruction, pulse retire once and check the landing pc.
  task automatic retire_expect(input string tag, input logic [31:0] exp_pc);
    int n;
    logic [1:0]  sj;
    logic        sb, sbn, sz;
    logic [31:0] si, sa;
    sj = Jump; sb = Branch; sbn = BranchN; sz = zero; si = imm; sa = alu_res;
    set_np(2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    imem_ready = 1'b1;
    n = 0;
    while (!inst_valid && n < 20) begin
      run_cycle();
      n++;
    end
    if (!inst_valid) check_eq("wait_valid_timeout", 32'd0, 32'd1);
    set_np(sj, sb, sbn, sz, si, sa);
    retire = 1'b1;
    run_cycle();
    retire = 1'b0;
    set_np(2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq(tag, pc, exp_pc);
    $display("retire %s: pc=%h expected %h", tag, pc, exp_pc);
  endtask

  int halt_cycles;
  logic [31:0] r;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[0] = 32'h0050_0093;
    model_reset();
    @(negedge clk);

    // Reset release with zero-wait memory.
    imem_ready = 1'b1;
    apply_reset(2);
    check_eq("c0_req",  imem_req,  32'd1);
    check_eq("c0_addr", imem_addr, 32'd0);
    run_cycle();
    check_eq("c1_valid",  inst_valid, 32'd1);
    check_eq("c1_opcode", OPcode,     32'h13);
    check_eq("c1_fun3",   Fun3,       32'd0);
    run_cycle();

    // Stalled memory: pc holds at 0 for four cycles, then retire -> 4.
    imem_ready = 1'b0;
    apply_reset(1);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_pc", pc, 32'd0);
      run_cycle();
    end
    check_eq("stall_pc", pc, 32'd0);
    imem_ready = 1'b1;
    run_cycle();
    retire_expect("seq", 32'd4);
    check_eq("pc_plus4_after_seq", pc_plus4, 32'd8);

    // Branches around pc 0x10.
    set_np(2'b01, 0, 0, 0, 32'd12, 0);          retire_expect("jal_to_10", 32'h10);
    set_np(2'b00, 1, 0, 1, 32'hFFFF_FFF8, 0);   retire_expect("beq_taken", 32'h08);
    set_np(2'b01, 0, 0, 0, 32'd8, 0);           retire_expect("jal_to_10b", 32'h10);
    set_np(2'b00, 1, 0, 0, 32'hFFFF_FFF8, 0);   retire_expect("beq_not_taken", 32'h14);
    set_np(2'b01, 0, 0, 0, 32'hFFFF_FFFC, 0);   retire_expect("jal_to_10c", 32'h10);
    set_np(2'b00, 0, 1, 0, 32'hFFFF_FFF8, 0);   retire_expect("bne_taken", 32'h08);
    set_np(2'b00, 1, 1, 1, 32'h20, 0);          retire_expect("beq_bne_both", 32'h28);
    set_np(2'b01, 0, 0, 0, 32'hFFFF_FFF8, 0);   retire_expect("jal_to_20", 32'h20);
    set_np(2'b01, 0, 0, 0, 32'h100, 0);         retire_expect("jal_100", 32'h120);
    set_np(2'b11, 0, 0, 0, 32'h40, 32'hFFFF_FFFD); retire_expect("jalr_prio", 32'hFFFF_FFFC);
    retire_expect("wrap", 32'h0);

    // Retire during FETCH is ignored.
    imem_ready = 1'b0;
    retire = 1'b1;
    set_np(2'b01, 0, 0, 0, 32'h40, 0);
    run_cycle();
    run_cycle();
    retire = 1'b0;
    check_eq("retire_in_fetch", pc, 32'h0);

    // Reset mid-FETCH, then mid-HOLD.
    apply_reset(1);
    imem_ready = 1'b1;
    run_cycle();
    check_eq("hold_before_rst", inst_valid, 32'd1);
    apply_reset(1);
    run_cycle();
    check_eq("resume_valid", inst_valid, 32'd1);

    // Misaligned jalr target halts the stage.
    set_np(2'b10, 0, 0, 0, 0, 32'h0000_0207);   retire_expect("jalr_mis", 32'h206);
    imem_ready = 1'b1;
    retire = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    retire = 1'b0;
    check_eq("halt_misalign", fetch_misalign, 32'd1);
    check_eq("halt_req",      imem_req,       32'd0);
    check_eq("halt_valid",    inst_valid,     32'd0);
    check_eq("halt_pc",       pc,             32'h206);
    apply_reset(1);

    // Randomized traffic.
    halt_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_halt) halt_cycles++;
      if ((m_halt && halt_cycles > 3) || ($urandom_range(0, 299) == 0)) begin
        halt_cycles = 0;
        apply_reset($urandom_range(1, 2));
      end
      imem_ready = ($urandom_range(0, 3) != 0);
      retire     = $urandom_range(0, 1);
      Jump       = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) Jump = 2'b00;
      Branch  = $urandom_range(0, 1);
      BranchN = $urandom_range(0, 1);
      zero    = $urandom_range(0, 1);
      r = $urandom();
      imm = ($urandom_range(0, 15) == 0) ? r : (r & 32'hFFFF_FFFC);
      r = $urandom();
      alu_res = ($urandom_range(0, 15) == 0) ? r : (r & 32'hFFFF_FFFD);
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
